// File: rtl/line_refill_ctrl.sv
// line_refill_ctrl: cache-miss refill engine placed after data_mem.
// Accepts one line request, optionally writes back the dirty victim line,
// then burst-reads the new line from a word-addressed synchronous RAM
// (1-cycle read latency) and returns it with a one-cycle done pulse.
// Optional build macro: CRITICAL_WORD_FIRST_EN (reads start at req_word and
// a crit_valid/crit_data pulse forwards the missed word as soon as it lands).
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, all req_* inputs are sampled on that edge
// only, and req_valid seen while busy is dropped, never queued.
module line_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int LINE_AW    = 8,
  localparam int WI        = $clog2(LINE_WORDS),
  localparam int MEM_AW    = LINE_AW + WI
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wb,
  input  logic [LINE_AW-1:0]       req_wb_line,
  input  logic [LINE_WORDS*32-1:0] req_wb_data,
  input  logic [LINE_AW-1:0]       req_fill_line,
  input  logic [WI-1:0]            req_word,
  output logic [LINE_WORDS*32-1:0] fill_data,
  output logic                     done,
  output logic                     busy,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [31:0]              mem_rdata,
  output logic [2:0]               dbg_state
`ifdef CRITICAL_WORD_FIRST_EN
  ,output logic                    crit_valid,
  output logic [31:0]              crit_data
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WB    = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state;
  logic [WI-1:0]             cnt;      // position in the current burst
  logic [LINE_AW-1:0]        wb_line;
  logic [LINE_AW-1:0]        fill_line;
  logic [LINE_WORDS*32-1:0]  wb_data;
  logic [WI-1:0]             start;    // first word index of the read burst
  logic [WI-1:0]             first;    // start index taken from the request
  logic [WI-1:0]             nxt;
  logic [WI-1:0]             cap_idx;
  logic                      last;

  assign dbg_state = state;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [WI-1:0] start_q;
  logic          crit_q;
  assign start      = start_q;
  assign first      = req_word;
  assign crit_valid = crit_q;
  assign crit_data  = crit_q ? mem_rdata : 32'd0;
`else
  logic unused_req_word;
  assign start           = '0;
  assign first           = '0;
  assign unused_req_word = ^req_word;
`endif

  // Burst bookkeeping: next position, end of burst, and the fill_data slot
  // that the word now on mem_rdata belongs to (issued one cycle earlier).
  always_comb begin
    nxt     = cnt + WI'(1);
    last    = (cnt == WI'(LINE_WORDS - 1));
    cap_idx = (state == S_DRAIN) ? WI'(start + cnt) : WI'(start + cnt - WI'(1));
  end

  // Main FSM; every output is registered and set one edge ahead of its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      fill_data <= '0;
      cnt       <= '0;
      wb_line   <= '0;
      fill_line <= '0;
      wb_data   <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      start_q   <= '0;
      crit_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            wb_line   <= req_wb_line;
            fill_line <= req_fill_line;
            wb_data   <= req_wb_data;
`ifdef CRITICAL_WORD_FIRST_EN
            start_q   <= req_word;
            crit_q    <= 1'b0;
`endif
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
            if (req_wb) begin
              state     <= S_WB;
              mem_we    <= 1'b1;
              mem_addr  <= {req_wb_line, WI'(0)};
              mem_wdata <= req_wb_data[31:0];
            end else begin
              state     <= S_RD;
              mem_re    <= 1'b1;
              mem_addr  <= {req_fill_line, first};
            end
          end
        end
        S_WB: begin
          if (last) begin
            state     <= S_RD;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_re    <= 1'b1;
            mem_addr  <= {fill_line, start};
          end else begin
            cnt       <= nxt;
            mem_addr  <= {wb_line, nxt};
            mem_wdata <= wb_data[nxt*32 +: 32];
          end
        end
        S_RD: begin
          if (cnt != '0) fill_data[cap_idx*32 +: 32] <= mem_rdata;
`ifdef CRITICAL_WORD_FIRST_EN
          crit_q <= (cnt == '0);
`endif
          if (last) begin
            state    <= S_DRAIN;
            mem_re   <= 1'b0;
            mem_addr <= '0;
          end else begin
            cnt      <= nxt;
            mem_addr <= {fill_line, WI'(start + nxt)};
          end
        end
        S_DRAIN: begin
          fill_data[cap_idx*32 +: 32] <= mem_rdata;
`ifdef CRITICAL_WORD_FIRST_EN
          crit_q <= 1'b0;
`endif
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          cnt       <= '0;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Directed bench for line_refill_ctrl: RAM model, driver tasks, scoreboard
// queue popped by an independent monitor, and a final report.
module tb_line_refill_ctrl;

  localparam int W = 192;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wb;
  logic [7:0]    req_wb_line;
  logic [127:0]  req_wb_data;
  logic [7:0]    req_fill_line;
  logic [1:0]    req_word;
  logic [127:0]  fill_data;
  logic          done;
  logic          busy;
  logic [9:0]    mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_rdata;
  logic [2:0]    dbg_state;
`ifdef CRITICAL_WORD_FIRST_EN
  logic          crit_valid;
  logic [31:0]   crit_data;
  logic [39:0]   exp_crit_q[$];
`endif

  logic [W-1:0]  exp_q[$];
  logic [31:0]   ram [0:1023];
  int            cyc;
  int            acc_cyc;
  int            n_cmp;
  int            n_bad;

  line_refill_ctrl #(.LINE_WORDS(4), .LINE_AW(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wb        (req_wb),
    .req_wb_line   (req_wb_line),
    .req_wb_data   (req_wb_data),
    .req_fill_line (req_fill_line),
    .req_word      (req_word),
    .fill_data     (fill_data),
    .done          (done),
    .busy          (busy),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata),
    .dbg_state     (dbg_state)
`ifdef CRITICAL_WORD_FIRST_EN
    ,.crit_valid   (crit_valid),
    .crit_data     (crit_data)
`endif
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous backing RAM, 1-cycle read latency
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] <= 32'd0;
    ram[20] <= 32'h11; ram[21] <= 32'h22; ram[22] <= 32'h33; ram[23] <= 32'h44;
    ram[28] <= 32'h70; ram[29] <= 32'h71; ram[30] <= 32'h72; ram[31] <= 32'h73;
  end

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic [7:0] rel, input logic we, input logic re,
                                      input logic dn, input logic [9:0] addr, input logic [127:0] data);
    return {43'd0, rel, we, re, dn, addr, data};
  endfunction

  // expected transaction, cycles relative to the accept edge plus off
  task automatic push_txn(input int off, input logic wb, input logic [7:0] wl, input logic [127:0] wd,
                          input logic [7:0] fl, input logic [1:0] wdx, input logic [127:0] ef);
    int rb;
    logic [1:0] st;
    logic [1:0] idx;
    if (wb)
      for (int k = 0; k < 4; k++)
        exp_q.push_back(pk(8'(off + 1 + k), 1'b1, 1'b0, 1'b0, {wl, 2'(k)}, {96'd0, wd[k*32 +: 32]}));
    rb = wb ? off + 5 : off + 1;
`ifdef CRITICAL_WORD_FIRST_EN
    st = wdx;
`else
    st = 2'd0;
`endif
    for (int k = 0; k < 4; k++) begin
      idx = st + 2'(k);
      exp_q.push_back(pk(8'(rb + k), 1'b0, 1'b1, 1'b0, {fl, idx}, 128'd0));
    end
    exp_q.push_back(pk(8'(rb + 5), 1'b0, 1'b0, 1'b1, 10'd0, ef));
`ifdef CRITICAL_WORD_FIRST_EN
    exp_crit_q.push_back({8'(rb + 1), ef[st*32 +: 32]});
`endif
  endtask

  // monitor: pops the scoreboard whenever the DUT shows a memory op or done
  always @(negedge clk) begin
    logic [W-1:0] act;
    if (rst_n) begin
      if (mem_we && mem_re) chk("we_re_excl", 1, 0);
      if (mem_we || mem_re || done) begin
        act = pk(8'(cyc - acc_cyc), mem_we, mem_re, done, done ? 10'd0 : mem_addr,
                 done ? fill_data : (mem_we ? {96'd0, mem_wdata} : 128'd0));
        if (exp_q.size() == 0) chk("unexpected_op", act, 0);
        else chk("txn_event", act, exp_q.pop_front());
      end
`ifdef CRITICAL_WORD_FIRST_EN
      if (crit_valid) begin
        if (exp_crit_q.size() == 0) chk("unexpected_crit", {8'(cyc - acc_cyc), crit_data}, 0);
        else chk("crit_word", {8'(cyc - acc_cyc), crit_data}, exp_crit_q.pop_front());
      end
`endif
    end
  end

  // driver: one request, then wait for done and check busy/idle/hold
  task automatic run_txn(input logic wb, input logic [7:0] wl, input logic [127:0] wd,
                         input logic [7:0] fl, input logic [1:0] wdx, input logic [127:0] ef);
    int busy_low;
    bit seen;
    @(negedge clk);
    req_valid = 1'b1; req_wb = wb; req_wb_line = wl; req_wb_data = wd;
    req_fill_line = fl; req_word = wdx;
    acc_cyc = cyc;
    push_txn(0, wb, wl, wd, fl, wdx, ef);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wb = 1'($urandom_range(0, 1));
    req_wb_line = 8'($urandom_range(0, 255));
    req_fill_line = 8'($urandom_range(0, 255));
    req_word = 2'($urandom_range(0, 3));
    req_wb_data = {$urandom, $urandom, $urandom, $urandom};
    busy_low = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (done) seen = 1'b1;
    end
    chk("done_seen", W'(seen), 1);
    chk("busy_span", busy_low, 0);
    @(negedge clk);
    chk("idle_after_done", {busy, req_ready, done}, 3'b010);
    chk("fill_hold", fill_data, ef);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; acc_cyc = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0; req_wb_line = '0;
    req_wb_data = '0; req_fill_line = '0; req_word = '0;

    // reset values
    repeat (3) @(negedge clk);
    chk("reset_vals", {req_ready, busy, done, mem_we, mem_re, mem_addr, mem_wdata, fill_data, dbg_state},
        {1'b1, 177'd0});
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_mem", {mem_we, mem_re, busy, req_ready}, 4'b0001);
    end

    // fill only (req_word=2 matters only with critical-word-first)
    run_txn(1'b0, 8'd0, 128'd0, 8'd5, 2'd2, 128'h00000044_00000033_00000022_00000011);

    // evict line 2 + fill line 7
    run_txn(1'b1, 8'd2, 128'h000000A3_000000A2_000000A1_000000A0, 8'd7, 2'd0,
            128'h00000073_00000072_00000071_00000070);

    // written-back line reads back
    run_txn(1'b0, 8'd0, 128'd0, 8'd2, 2'd3, 128'h000000A3_000000A2_000000A1_000000A0);

    // same line for wb and fill, req_valid held across two transactions
    @(negedge clk);
    req_valid = 1'b1; req_wb = 1'b1; req_wb_line = 8'd3; req_fill_line = 8'd3; req_word = 2'd1;
    req_wb_data = 128'h000000C3_000000C2_000000C1_000000C0;
    acc_cyc = cyc;
    push_txn(0, 1'b1, 8'd3, 128'h000000C3_000000C2_000000C1_000000C0, 8'd3, 2'd1,
             128'h000000C3_000000C2_000000C1_000000C0);
    push_txn(11, 1'b1, 8'd3, 128'h000000C3_000000C2_000000C1_000000C0, 8'd3, 2'd1,
             128'h000000C3_000000C2_000000C1_000000C0);
    repeat (12) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("held_queue", exp_q.size(), 0);
    chk("held_idle", {busy, req_ready}, 2'b01);
    chk("held_fill", fill_data, 128'h000000C3_000000C2_000000C1_000000C0);

    // reset in the 2nd writeback cycle
    @(negedge clk);
    req_valid = 1'b1; req_wb = 1'b1; req_wb_line = 8'd9; req_fill_line = 8'd7; req_word = 2'd0;
    req_wb_data = 128'h000000B3_000000B2_000000B1_000000B0;
    acc_cyc = cyc;
    exp_q.push_back(pk(8'd1, 1'b1, 1'b0, 1'b0, {8'd9, 2'd0}, 128'h000000B0));
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midop_reset", {mem_we, mem_re, busy, req_ready, dbg_state}, 7'b0001000);
    chk("midop_queue", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {mem_we, mem_re, busy, req_ready}, 4'b0001);

    // fill after the aborted transaction completes normally
    run_txn(1'b0, 8'd0, 128'd0, 8'd2, 2'd1, 128'h000000A3_000000A2_000000A1_000000A0);

    repeat (3) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
`ifdef CRITICAL_WORD_FIRST_EN
    chk("final_crit_queue", exp_crit_q.size(), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
